// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, bit/frame timing derivation and the
// transmit scheduler FSM state type.
package uart_pkg;

  localparam int FrameWidth = 10;

  typedef struct packed {
    logic [31:0] ticks_per_bit;
    logic [31:0] frame_cycles;
  } uart_timing_t;

  // Frame cycles add two clocks for the transmitter's load and stop-bit turnaround.
  function automatic uart_timing_t uart_timing(input int clock_frequency, input int baud_rate);
    uart_timing_t t;
    t.ticks_per_bit = 32'(clock_frequency / baud_rate);
    t.frame_cycles  = 32'(FrameWidth) * t.ticks_per_bit + 32'd2;
    return t;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } sched_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous circular-buffer FIFO with extra-MSB pointers for full/empty.
// Occupancy output exists only when UART_TX_SCHED_LEVEL_EN is defined.
module uart_sync_fifo #(
  parameter int Depth = 16,
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty
`ifdef UART_TX_SCHED_LEVEL_EN
  ,
  output logic [$clog2(Depth):0] level
`endif
);

  localparam int AddrWidth = $clog2(Depth);

  logic [AddrWidth:0] wr_ptr;
  logic [AddrWidth:0] rd_ptr;
  logic [Width-1:0]   mem [Depth];
  logic               do_push;
  logic               do_pop;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign full    = (wr_ptr[AddrWidth] != rd_ptr[AddrWidth]) &&
                   (wr_ptr[AddrWidth-1:0] == rd_ptr[AddrWidth-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AddrWidth-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AddrWidth+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AddrWidth+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AddrWidth-1:0]] <= push_data;
  end

`ifdef UART_TX_SCHED_LEVEL_EN
  assign level = wr_ptr - rd_ptr;
`endif

endmodule

// File: rtl/uart_tx_scheduler.sv
// Buffers producer bytes and paces one-cycle send pulses so the busy-less UART
// transmitter never receives a request mid-frame. Optional o_level: UART_TX_SCHED_LEVEL_EN.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115200,
  parameter int Depth          = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_send,
  output logic [7:0] o_frame,
  output logic       o_busy
`ifdef UART_TX_SCHED_LEVEL_EN
  ,
  output logic [$clog2(Depth):0] o_level
`endif
);

  localparam uart_timing_t Timing      = uart_timing(ClockFrequency, BaudRate);
  localparam int           FrameCycles = int'(Timing.frame_cycles);
  localparam int           CountWidth  = $clog2(FrameCycles);
  // SEND plus (FrameCycles-2 .. 0) in WAIT spaces consecutive sends FrameCycles apart.
  localparam logic [CountWidth-1:0] ReloadValue = CountWidth'(FrameCycles - 2);

  sched_state_t          state;
  sched_state_t          next_state;
  logic [CountWidth-1:0] count;
  logic [CountWidth-1:0] next_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [7:0]            head;
  logic                  pop;

  assign pop     = (state == SEND);
  assign o_ready = !fifo_full;
  assign o_busy  = (state != IDLE) || !fifo_empty;

  uart_sync_fifo #(
    .Depth(Depth),
    .Width(8)
  ) fifo_inst (
    .clk      (CLK),
    .rst      (RST),
    .push     (i_valid),
    .push_data(i_data),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
`ifdef UART_TX_SCHED_LEVEL_EN
    ,
    .level    (o_level)
`endif
  );

  always_comb begin
    next_state = state;
    next_count = count;
    case (state)
      IDLE: if (!fifo_empty) next_state = SEND;
      SEND: begin
        next_count = ReloadValue;
        next_state = WAIT;
      end
      WAIT: begin
        if (count == '0) next_state = fifo_empty ? IDLE : SEND;
        else             next_count = count - CountWidth'(1);
      end
      default: next_state = IDLE;
    endcase
  end

  // o_send/o_frame are registered copies of the SEND decision; o_frame holds afterwards.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      count   <= '0;
      o_send  <= 1'b0;
      o_frame <= 8'h00;
    end else begin
      state  <= next_state;
      count  <= next_count;
      o_send <= (next_state == SEND);
      if (next_state == SEND) o_frame <= head;
    end
  end

endmodule
